// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one async_transmitter among NREQ
// byte producers. A granted requester keeps the transmitter until its
// 'last' byte has drained, so packets never interleave on the wire.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- revokes a grant whose owner
// stalls for TIMEOUT cycles in the middle of a packet.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              timeout_evt
);

  localparam int IdxW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : gParamCheck
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT_HI, DRAIN} state_t;

  state_t          state;
  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] gIdx;
  logic            lastQ;
  logic            winFound;
  logic [IdxW-1:0] winIdx;
  logic            accept;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] idleCnt;
`else
  assign timeout_evt = 1'b0;
`endif

  // Owner's byte is taken only while the transmitter is free
  assign accept    = (state == LOAD) && req_valid[gIdx] && !tx_busy;
  assign req_ready = accept ? (NREQ'(1) << gIdx) : '0;

  // Pick the first valid requester after ptr, wrapping modulo NREQ
  always_comb begin
    logic [IdxW-1:0] cand;
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IdxW'((int'(ptr) + k) % NREQ);
      if (!winFound && req_valid[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  // Packet-level FSM: arbitrate, hand one byte at a time to the transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      lastQ    <= 1'b0;
      ptr      <= IdxW'(NREQ - 1);
      gIdx     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idleCnt     <= '0;
      timeout_evt <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_evt <= 1'b0;
`endif
      case (state)
        IDLE: begin
          grant <= '0;
          // tx_busy gate also lets a byte in flight across a reset finish
          if (winFound && !tx_busy) begin
            grant <= NREQ'(1) << winIdx;
            gIdx  <= winIdx;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            tx_data  <= req_data[{gIdx, 3'b000} +: 8];
            tx_start <= 1'b1;
            lastQ    <= req_last[gIdx];
            state    <= LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
            idleCnt  <= '0;
          end else if (!req_valid[gIdx]) begin
            if (idleCnt == CntW'(TIMEOUT - 1)) begin
              idleCnt     <= '0;
              timeout_evt <= 1'b1;
              ptr         <= gIdx;
              grant       <= '0;
              state       <= IDLE;
            end else begin
              idleCnt <= idleCnt + CntW'(1);
            end
`endif
          end
        end
        LAUNCH: state <= WAIT_HI;
        // Transmitter raises busy one cycle after start
        WAIT_HI: if (tx_busy) state <= DRAIN;
        DRAIN: begin
          if (!tx_busy) begin
            if (lastQ) begin
              ptr   <= gIdx;
              grant <= '0;
              state <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `async_transmitter` among `NREQ` byte producers, such as a result dumper, a debug tap and a command echo. Each requester offers bytes through a valid/ready handshake and marks the final byte of a packet with `last`. The granted requester holds the transmitter until its `last` byte has been sent, so packets never interleave on the wire. The block sits between the producers and the transmitter's `TxD_start`/`TxD_data`/`TxD_busy` pins.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1024: idle cycles allowed inside a locked packet. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: requester i has a byte on offer.
- `req_data` in 8*NREQ: byte of requester i is at `[8i+7:8i]`.
- `req_last` in NREQ: the offered byte ends requester i's packet.
- `req_ready` out NREQ: byte of requester i accepted this cycle. Combinational.
- `grant` out NREQ: one-hot owner of the transmitter, or all zero. Registered.
- `tx_start` out 1: to `TxD_start`. Registered, single-cycle pulse.
- `tx_data` out 8: to `TxD_data`. Registered.
- `tx_busy` in 1: from `TxD_busy`.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by timeout. Tied to 0 without the macro.

## Operation
State machine states: IDLE, LOAD, LAUNCH, WAIT_HI, DRAIN.

- **IDLE**
  - `grant` = 0.
  - Arbitration runs only when `|req_valid` and `!tx_busy`.
  - The winner is the first valid index after `ptr`, searching upward and wrapping modulo NREQ.
  - On a win: `grant` is set to the winner's one-hot and the state moves to LOAD.
- **LOAD**
  - `req_ready[g] = req_valid[g] & !tx_busy`, where g is the granted index.
  - On acceptance: `tx_data` <= `req_data[g]`, `tx_start` <= 1, `last_q` <= `req_last[g]`, and the state moves to LAUNCH.
- **LAUNCH**
  - `tx_start` is high for this one cycle only; it is cleared on exit.
  - The state moves to WAIT_HI.
- **WAIT_HI**
  - Waits until `tx_busy` = 1. This covers the one-cycle lag between start and busy in the transmitter.
  - Then moves to DRAIN.
- **DRAIN**
  - Waits until `tx_busy` = 0.
  - If `last_q` = 1: `ptr` <= g, `grant` <= 0, and the state moves to IDLE.
  - Otherwise the state returns to LOAD with the same grant.
- **Priority pointer:** `ptr` updates only at packet end, which gives round-robin fairness across packets, not across bytes.
- **Non-granted requesters:** `req_ready` stays 0 for every requester that does not hold the grant.
- **tx_data hold:** `tx_data` keeps its value until the next acceptance.
- **Simultaneous valids in IDLE:** the lowest index after `ptr` wins. Bytes are never dropped; losers simply keep `valid` asserted.
- **Reset (asynchronous, any state):**
  - `grant` = 0, `req_ready` = 0, `tx_start` = 0, `tx_data` = 8'h00, `timeout_evt` = 0, `last_q` = 0.
  - `ptr` = NREQ-1, so index 0 has the highest priority first.
  - The state returns to IDLE.
  - The transmitter has no reset. If reset lands mid-byte, IDLE blocks arbitration until `tx_busy` falls, so the byte in flight completes undisturbed.

## Timing
- **Arbitration latency:** `req_valid` seen in IDLE at cycle 0 → `grant` at cycle 1 → `req_ready` at cycle 1 if still valid → `tx_start` at cycle 2.
- **Start pulse:** exactly one clock per accepted byte.
- **Back-to-back bytes:** gap from the `tx_busy` fall to the next `tx_start` is 2 cycles (DRAIN→LOAD, LOAD→LAUNCH), provided `valid` is held.
- **Grant changes** happen only in IDLE. The grant drops the cycle after `tx_busy` falls at packet end.
- **Requester data** must be stable only in the cycle where `req_ready` is high.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - A counter (width $clog2(TIMEOUT+1)) counts LOAD cycles with `req_valid[g]` = 0. It clears on any acceptance.
  - When the count reaches `TIMEOUT`, the grant is revoked: `ptr` <= g, state → IDLE, `timeout_evt` pulses for 1 cycle.
  - This prevents a stalled producer from locking the wire.
- **`UART_ARB_TIMEOUT_EN` undefined:**
  - There is no counter, and the grant is held indefinitely until `last`.
  - `timeout_evt` = 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DRAIN → all outputs at reset values immediately; after release, no `tx_start` while `tx_busy`=1; arbitration resumes once it falls.
- **Single packet:** requester 1 sends 3 bytes 8'hA5, 8'h5A, 8'h3C with `last` on the third → exactly 3 `tx_start` pulses carrying those bytes in order; `grant` = 4'b0010 throughout, then 0.
- **Contention:** all 4 requesters valid with 1-byte packets (`last`=1) after reset → grant order 0, 1, 2, 3, 0. With requester 2 holding a 2-byte packet, requesters 0 and 3 waiting are not served until 2's `last` byte has drained.
- **Busy handshake:** a transmitter model with busy delayed 1 cycle after start, held 12 cycles → no second `tx_start` while busy; gap from busy fall to the next start = 2 cycles.
- **Timeout (macro on, `TIMEOUT`=8):** requester 0 sends one non-last byte then drops `valid` → after 8 LOAD cycles `timeout_evt` pulses, grant clears, and waiting requester 1 is granted next.
- **Timeout (macro off):** same stimulus → grant held for 1000 cycles, `timeout_evt` stays 0.
